// File: rtl/pong_match_if.sv
// Signal bundle between the pong match sequencer and its surroundings:
// per-frame/player event inputs and the game-state outputs.
// The slave modport is the sequencer; the master modport is the environment.
interface pong_match_if;
    logic       frame_tick;
    logic       start;
    logic       pause_req;
    logic       hit;
    logic       miss_left;
    logic       miss_right;
    logic       pause;
    logic       ball_load;
    logic       serve_dir;
    logic [3:0] score1_tens;
    logic [3:0] score1_ones;
    logic [3:0] score2_tens;
    logic [3:0] score2_ones;
    logic [1:0] winner;
    logic [2:0] state;
    logic [1:0] speed_level;

    modport master (
        output frame_tick, start, pause_req, hit, miss_left, miss_right,
        input  pause, ball_load, serve_dir,
        input  score1_tens, score1_ones, score2_tens, score2_ones,
        input  winner, state, speed_level
    );

    modport slave (
        input  frame_tick, start, pause_req, hit, miss_left, miss_right,
        output pause, ball_load, serve_dir,
        output score1_tens, score1_ones, score2_tens, score2_ones,
        output winner, state, speed_level
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: attract, serve delay, rally, point, user pause and
// game over. Drives the physics pause line and ball re-centre pulse, and
// keeps both players' BCD scores. All outputs are registered.
// Optional macro PONG_SPEEDUP_EN: enables the paddle-hit speed stepping.
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE       = 11,
    parameter int unsigned SERVE_FRAMES    = 60,
    parameter int unsigned SPEEDUP_HITS    = 4,
    parameter int unsigned MAX_SPEED_LEVEL = 3
) (
    input  logic         clk,
    input  logic         reset,
    pong_match_if.slave  bus
);

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        SERVE     = 3'd1,
        RALLY     = 3'd2,
        POINT     = 3'd3,
        PAUSED    = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [7:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

    // Out-of-range parameters stop elaboration rather than building a broken match.
    if (WIN_SCORE == 0 || WIN_SCORE > 99 || SERVE_FRAMES == 0 || SERVE_FRAMES > 255 ||
        SPEEDUP_HITS == 0 || SPEEDUP_HITS > 255 || MAX_SPEED_LEVEL > 3) begin : g_param_check
        $error("pong_match_ctrl: parameter out of range");
    end

    state_t     state_q, state_d;
    logic       start_q;
    logic       start_rise;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] score1_q, score1_d;
    logic [7:0] score2_q, score2_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_dir_q, serve_dir_d;
    logic       pause_q, pause_d;
    logic       ball_load_q, ball_load_d;

    assign start_rise = bus.start & ~start_q;

    // BCD increment, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ATTRACT;
            start_q     <= 1'b1;
            frame_cnt_q <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            winner_q    <= '0;
            serve_dir_q <= 1'b0;
            pause_q     <= 1'b1;
            ball_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            frame_cnt_q <= frame_cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            pause_q     <= pause_d;
            ball_load_q <= ball_load_d;
        end
    end

    // Next-state and next-output decode; pause/ball_load are registered, so
    // they are derived from the state being entered.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        ball_load_d = 1'b0;

        case (state_q)
            ATTRACT, GAME_OVER: begin
                if (start_rise) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    winner_d    = '0;
                    frame_cnt_d = '0;
                    ball_load_d = 1'b1;
                    serve_dir_d = 1'b0;
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = RALLY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            RALLY: begin
                if (bus.miss_left) begin
                    score2_d    = bcd_inc(score2_q);
                    serve_dir_d = 1'b0;
                    ball_load_d = 1'b1;
                    state_d     = POINT;
                end else if (bus.miss_right) begin
                    score1_d    = bcd_inc(score1_q);
                    serve_dir_d = 1'b1;
                    ball_load_d = 1'b1;
                    state_d     = POINT;
                end else if (bus.pause_req) begin
                    state_d = PAUSED;
                end
            end
            POINT: begin
                // serve_dir was set toward the loser, so it identifies the scorer.
                if ((serve_dir_q ? score1_q : score2_q) == WIN_BCD) begin
                    winner_d = serve_dir_q ? 2'd1 : 2'd2;
                    state_d  = GAME_OVER;
                end else begin
                    frame_cnt_d = '0;
                    state_d     = SERVE;
                end
            end
            PAUSED: begin
                if (bus.pause_req)
                    state_d = RALLY;
            end
            default: state_d = ATTRACT;
        endcase

        pause_d = (state_d != RALLY);
    end

`ifdef PONG_SPEEDUP_EN
    localparam logic [7:0] HIT_LAST  = 8'(SPEEDUP_HITS - 1);
    localparam logic [1:0] SPEED_MAX = 2'(MAX_SPEED_LEVEL);

    logic [7:0] hit_cnt_q, hit_cnt_d;
    logic [1:0] speed_q, speed_d;

    // Hit counting in RALLY; every ball re-centre restarts at the base speed.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        speed_d   = speed_q;
        if (ball_load_d) begin
            hit_cnt_d = '0;
            speed_d   = '0;
        end else if (state_q == RALLY && bus.hit) begin
            if (hit_cnt_q == HIT_LAST) begin
                hit_cnt_d = '0;
                if (speed_q < SPEED_MAX)
                    speed_d = speed_q + 2'd1;
            end else begin
                hit_cnt_d = hit_cnt_q + 8'd1;
            end
        end
    end

    // Hit counter and speed level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q <= '0;
            speed_q   <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign bus.speed_level = speed_q;
`else
    assign bus.speed_level = '0;
`endif

    assign bus.state       = state_q;
    assign bus.pause       = pause_q;
    assign bus.ball_load   = ball_load_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.score1_tens = score1_q[7:4];
    assign bus.score1_ones = score1_q[3:0];
    assign bus.score2_tens = score2_q[7:4];
    assign bus.score2_ones = score2_q[3:0];
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl (SERVE_FRAMES = 3,
// WIN_SCORE = 3, SPEEDUP_HITS = 2). Expected snapshots are queued as each
// step is driven and compared after the following clock edge.
module tb_pong_match_ctrl;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       p;
        logic       bl;
        logic       dir;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [1:0] w;
        logic [1:0] sp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    pong_match_if bus ();

    pong_match_ctrl #(
        .WIN_SCORE      (3),
        .SERVE_FRAMES   (3),
        .SPEEDUP_HITS   (2),
        .MAX_SPEED_LEVEL(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] e_s1 = '0;
    logic [7:0] e_s2 = '0;
    logic       e_dir = 1'b0;
    logic [1:0] e_w  = '0;
    logic [1:0] e_sp = '0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic p, input logic bl);
        exp_t e;
        e.tag = tag; e.st = st; e.p = p; e.bl = bl;
        e.dir = e_dir; e.s1 = e_s1; e.s2 = e_s2; e.w = e_w; e.sp = e_sp;
        sb.push_back(e);
    endtask

    task automatic step_check();
        exp_t e;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.pause_req  = 1'b0;
        bus.hit        = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: observed empty queue required one entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".state"},     8'(bus.state),                          8'(e.st));
            chk({e.tag, ".pause"},     8'(bus.pause),                          8'(e.p));
            chk({e.tag, ".ball_load"}, 8'(bus.ball_load),                      8'(e.bl));
            chk({e.tag, ".serve_dir"}, 8'(bus.serve_dir),                      8'(e.dir));
            chk({e.tag, ".score1"},    {bus.score1_tens, bus.score1_ones},     e.s1);
            chk({e.tag, ".score2"},    {bus.score2_tens, bus.score2_ones},     e.s2);
            chk({e.tag, ".winner"},    8'(bus.winner),                         8'(e.w));
            chk({e.tag, ".speed"},     8'(bus.speed_level),                    8'(e.sp));
        end
    endtask

    // Three frame ticks from a freshly cleared serve counter release the ball.
    task automatic serve_to_rally(input string tag);
        bus.frame_tick = 1'b1; push({tag, ".tick1"}, 3'd1, 1'b1, 1'b0); step_check();
        bus.frame_tick = 1'b1; push({tag, ".tick2"}, 3'd1, 1'b1, 1'b0); step_check();
        bus.frame_tick = 1'b1; push({tag, ".tick3"}, 3'd2, 1'b0, 1'b0); step_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.frame_tick = 1'b0;
        bus.pause_req  = 1'b0;
        bus.hit        = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;

        // Reset with start held: attract, paused, nothing pending.
        push("reset0", 3'd0, 1'b1, 1'b0); step_check();
        push("reset1", 3'd0, 1'b1, 1'b0); step_check();
        reset = 1'b0;
        push("start_held", 3'd0, 1'b1, 1'b0); step_check();
        push("start_held2", 3'd0, 1'b1, 1'b0); step_check();
        bus.start = 1'b0;
        push("start_low", 3'd0, 1'b1, 1'b0); step_check();
        bus.start = 1'b1;
        push("start_go", 3'd1, 1'b1, 1'b1); step_check();
        push("serve_idle", 3'd1, 1'b1, 1'b0); step_check();
        serve_to_rally("serve1");

        // Player 1 scores.
        bus.miss_right = 1'b1;
        e_s1 = 8'h01; e_dir = 1'b1;
        push("p1_point", 3'd3, 1'b1, 1'b1); step_check();
        push("p1_serve", 3'd1, 1'b1, 1'b0); step_check();
        serve_to_rally("serve2");

        // Simultaneous misses: left side wins.
        bus.miss_left = 1'b1; bus.miss_right = 1'b1;
        e_s2 = 8'h01; e_dir = 1'b0;
        push("both_point", 3'd3, 1'b1, 1'b1); step_check();
        push("both_serve", 3'd1, 1'b1, 1'b0); step_check();
        serve_to_rally("serve3");

        // User pause ignores misses, hits and frame ticks.
        bus.pause_req = 1'b1;
        push("pause_on", 3'd4, 1'b1, 1'b0); step_check();
        bus.miss_left = 1'b1; bus.hit = 1'b1; bus.frame_tick = 1'b1;
        push("pause_hold", 3'd4, 1'b1, 1'b0); step_check();
        bus.pause_req = 1'b1;
        push("pause_off", 3'd2, 1'b0, 1'b0); step_check();

        // Paddle hits step the speed (two hits per step, saturating at 3).
        for (int i = 1; i <= 7; i++) begin
            bus.hit = 1'b1;
`ifdef PONG_SPEEDUP_EN
            e_sp = (i >= 6) ? 2'd3 : (i >= 4) ? 2'd2 : (i >= 2) ? 2'd1 : 2'd0;
`endif
            push("hits", 3'd2, 1'b0, 1'b0); step_check();
        end

        // Miss clears speed on the ball_load cycle.
        bus.miss_left = 1'b1; bus.hit = 1'b1;
        e_s2 = 8'h02; e_dir = 1'b0; e_sp = 2'd0;
        push("p2_point2", 3'd3, 1'b1, 1'b1); step_check();
        push("p2_serve2", 3'd1, 1'b1, 1'b0); step_check();
        serve_to_rally("serve4");

        // Winning point for player 2.
        bus.miss_left = 1'b1;
        e_s2 = 8'h03;
        push("win_point", 3'd3, 1'b1, 1'b1); step_check();
        e_w = 2'd2;
        push("game_over", 3'd5, 1'b1, 1'b0); step_check();
        bus.miss_left = 1'b1; bus.miss_right = 1'b1; bus.hit = 1'b1;
        bus.pause_req = 1'b1; bus.frame_tick = 1'b1;
        push("over_ignore", 3'd5, 1'b1, 1'b0); step_check();
        bus.start = 1'b0;
        push("over_release", 3'd5, 1'b1, 1'b0); step_check();
        bus.start = 1'b1;
        e_s1 = '0; e_s2 = '0; e_w = '0; e_dir = 1'b0;
        push("restart", 3'd1, 1'b1, 1'b1); step_check();
        serve_to_rally("serve5");

        // Mid-match reset returns to attract without a ball_load pulse.
        bus.miss_right = 1'b1;
        e_s1 = 8'h01; e_dir = 1'b1;
        push("p1_point3", 3'd3, 1'b1, 1'b1); step_check();
        push("p1_serve3", 3'd1, 1'b1, 1'b0); step_check();
        reset = 1'b1;
        e_s1 = '0; e_dir = 1'b0;
        push("mid_reset", 3'd0, 1'b1, 1'b0); step_check();
        reset = 1'b0;
        push("post_reset", 3'd0, 1'b1, 1'b0); step_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the pong game. It sits between the per-frame physics/renderer datapath and the player inputs. It owns the game FSM: attract, serve delay, rally, point scored, user pause and game over. It drives the datapath pause line and the ball re-centre load, and holds the BCD scores shown by the score text renderers and the HEX displays.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99.
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; legal range 1..255.
SPEEDUP_HITS, 4, paddle hits per speed step (used only with the optional feature).
MAX_SPEED_LEVEL, 3, saturation value of speed_level; legal range 0..3.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per video frame
start  in  1  start button level, synchronised externally; edge detected internally
pause_req  in  1  one-cycle pulse that toggles user pause
hit  in  1  one-cycle pulse when the ball bounces off a paddle
miss_left  in  1  one-cycle pulse when the ball leaves the left edge; player 2 scores
miss_right  in  1  one-cycle pulse when the ball leaves the right edge; player 1 scores
pause  out  1  freezes the physics datapath; low only in RALLY
ball_load  out  1  one-cycle pulse that reloads the ball to the centre
serve_dir  out  1  0 = serve toward player 1 (left), 1 = serve toward player 2 (right)
score1_tens, score1_ones  out  4 each  player 1 score in BCD
score2_tens, score2_ones  out  4 each  player 2 score in BCD
winner  out  2  0 = none, 1 = player 1, 2 = player 2
state  out  3  current FSM state encoding
speed_level  out  2  ball speed step for the physics velocity select

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = ATTRACT, pause = 1, ball_load = 0, serve_dir = 0.
  - All score digits = 0, winner = 0, speed_level = 0.
  - Serve frame counter = 0, hit counter = 0.
  - start_q = 1, so a button held through reset does not start a match.
- Start edge: start_rise = start & ~start_q. start_q updates every cycle.
- State encoding: ATTRACT = 0, SERVE = 1, RALLY = 2, POINT = 3, PAUSED = 4, GAME_OVER = 5.
- ATTRACT and GAME_OVER:
  - pause = 1.
  - On start_rise: clear scores and winner, clear the frame counter, pulse ball_load, set serve_dir = 0, go to SERVE.
  - All other inputs are ignored.
- SERVE:
  - pause = 1.
  - The frame counter increments on each frame_tick.
  - On the frame_tick where counter == SERVE_FRAMES-1: clear the counter and go to RALLY. pause falls on the following cycle.
  - hit, miss_* and pause_req are ignored.
- RALLY:
  - pause = 0.
  - miss_left: increment player 2's score, set serve_dir = 0, go to POINT.
  - miss_right: increment player 1's score, set serve_dir = 1, go to POINT.
  - miss_left and miss_right in the same cycle: miss_left wins and miss_right is dropped.
  - A miss takes priority over hit and pause_req in the same cycle.
  - A lone pause_req goes to PAUSED.
- POINT (exactly one cycle):
  - pause = 1, ball_load = 1 during this cycle.
  - If the scorer's new score == WIN_SCORE: set winner, go to GAME_OVER.
  - Otherwise clear the frame counter and go to SERVE.
- PAUSED:
  - pause = 1.
  - The frame and hit counters are frozen; hit and miss_* are ignored.
  - pause_req returns to RALLY.
- Timing from a miss pulse at cycle N:
  - Cycle N+1: state = POINT, score updated, ball_load = 1.
  - Cycle N+2: state = SERVE or GAME_OVER.
- BCD increment:
  - ones 9 -> 0 with tens+1.
  - Score saturates at 99; it is unreachable when WIN_SCORE ≤ 99.
- Reset mid-match returns to the reset values on the next edge. No ball_load pulse is generated.

Optional Feature:
PONG_SPEEDUP_EN
- Defined:
  - The hit counter counts hit pulses in RALLY only.
  - When the counter reaches SPEEDUP_HITS: clear it and increment speed_level, saturating at MAX_SPEED_LEVEL.
  - speed_level and the hit counter clear on every ball_load.
- Undefined: speed_level is tied to 0 and there is no hit counter logic.

Test Plan:
Bench parameters: SERVE_FRAMES = 3, WIN_SCORE = 3.
1. Reset with start held high, then keep start high -> state stays 0 and pause = 1. Release start and press again -> ball_load pulses 1 cycle, state = 1; after 3 frame_ticks state = 2 and pause = 0 one cycle later.
2. In RALLY, pulse miss_right -> next cycle state = 3, ball_load = 1, score1 = 0/1, serve_dir = 1; following cycle state = 1.
3. In RALLY, pulse miss_left and miss_right together -> only score2 increments to 0/1, serve_dir = 0.
4. Third miss_left -> score2 = 0/3, state 3 then 5, winner = 2. Further miss and hit pulses change nothing. start_rise -> scores = 0, winner = 0, state = 1.
5. In RALLY, pulse pause_req -> state = 4, pause = 1, and a miss_left during pause leaves scores unchanged. Pulse pause_req again -> state = 2.
6. With PONG_SPEEDUP_EN, SPEEDUP_HITS = 2: 7 hit pulses in RALLY -> speed_level = 3 (saturated). A miss resets speed_level to 0 on the ball_load cycle.
